reg_hazard_tracker: RTL

Parametrised register-hazard tracker for the pipelined MIPS CPU, sitting in the ID stage. It decodes per-instruction source-register usage and keeps a shift-register scoreboard of in-flight destination writes. From these it produces the ID-stage stall, per-operand forwarding selects and a saturating stall-cycle counter. It replaces stand-alone combinational usage decoding plus ad-hoc hazard compares.

---
 rtl/hazard_pkg.sv | 52 +++++
 rtl/reg_usage_decode.sv | 47 ++++
 rtl/reg_hazard_tracker.sv | 104 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_pkg : opcode/func constants, scoreboard entry type, youngest-match search
// Rev 1.0
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int MAX_STAGES = 15;
  localparam int MAX_REG_W  = 8;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLEZ  = 6'd6;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_LBU   = 6'd36;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] F_SLL     = 6'd0;
  localparam logic [5:0] F_SRL     = 6'd2;
  localparam logic [5:0] F_SRA     = 6'd3;
  localparam logic [5:0] F_SRLV    = 6'd6;
  localparam logic [5:0] F_JR      = 6'd8;
  localparam logic [5:0] F_SYSCALL = 6'd12;
  localparam logic [5:0] F_ALU_LO  = 6'd32;
  localparam logic [5:0] F_ALU_HI  = 6'd39;
  localparam logic [5:0] F_SLT     = 6'd42;
  localparam logic [5:0] F_SLTU    = 6'd43;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dst;
    logic                 load;
  } sb_entry_t;

  // Bit k-1 of hits flags a match at stage k; returns the lowest such k, 0 if none.
  function automatic logic [3:0] youngest_match(input logic [MAX_STAGES-1:0] hits);
    logic [3:0] idx;
    idx = '0;
    for (int k = MAX_STAGES; k >= 1; k--) begin
      if (hits[k-1]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_usage_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_usage_decode : combinational R1/R2 source-usage table from op/func
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_usage_decode
  import hazard_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       r1_used,
  output logic       r2_used
);

  always_comb begin
    r1_used = 1'b0;
    r2_used = 1'b0;
    if (op == OP_RTYPE) begin
      case (func)
        F_SRLV, F_SYSCALL, F_SLT, F_SLTU: begin
          r1_used = 1'b1;
          r2_used = 1'b1;
        end
        F_JR: r1_used = 1'b1;
        F_SLL, F_SRL, F_SRA: r2_used = 1'b1;
        default: begin
          if (func >= F_ALU_LO && func <= F_ALU_HI) begin
            r1_used = 1'b1;
            r2_used = 1'b1;
          end
        end
      endcase
    end else begin
      case (op)
        OP_BEQ, OP_BNE, OP_SW: begin
          r1_used = 1'b1;
          r2_used = 1'b1;
        end
        OP_BLEZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_LBU:
          r1_used = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_hazard_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_hazard_tracker : ID-stage scoreboard producing stall, forward selects, stall count
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_hazard_tracker
  import hazard_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 2,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic [5:0]                     id_op,
  input  logic [5:0]                     id_func,
  input  logic [REG_W-1:0]               id_rs,
  input  logic [REG_W-1:0]               id_rt,
  input  logic [REG_W-1:0]               id_dst,
  input  logic                           id_we,
  input  logic                           id_load,
  input  logic                           flush,
  output logic                           r1_used,
  output logic                           r2_used,
  output logic                           stall,
  output logic [$clog2(STAGES+1)-1:0]    fwd_r1_sel,
  output logic [$clog2(STAGES+1)-1:0]    fwd_r2_sel,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int SEL_W = $clog2(STAGES+1);

  sb_entry_t             sb [1:STAGES];
  sb_entry_t             new_entry;
  logic                  dec_r1;
  logic                  dec_r2;
  logic [MAX_STAGES-1:0] hit1;
  logic [MAX_STAGES-1:0] hit2;
  logic [3:0]            k1;
  logic [3:0]            k2;
  logic                  ld1;
  logic                  ld2;
  logic                  haz1;
  logic                  haz2;
  logic [MAX_REG_W-1:0]  rs_ext;
  logic [MAX_REG_W-1:0]  rt_ext;

  reg_usage_decode u_decode (
    .op      (id_op),
    .func    (id_func),
    .r1_used (dec_r1),
    .r2_used (dec_r2)
  );

  assign r1_used = id_valid & dec_r1;
  assign r2_used = id_valid & dec_r2;
  assign rs_ext  = MAX_REG_W'(id_rs);
  assign rt_ext  = MAX_REG_W'(id_rt);

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    ld1  = 1'b0;
    ld2  = 1'b0;
    // Walk oldest to youngest so the load flag left behind belongs to the youngest hit.
    for (int k = STAGES; k >= 1; k--) begin
      hit1[k-1] = r1_used && (rs_ext != '0) && sb[k].valid && (sb[k].dst == rs_ext);
      hit2[k-1] = r2_used && (rt_ext != '0) && sb[k].valid && (sb[k].dst == rt_ext);
      if (hit1[k-1]) ld1 = sb[k].load;
      if (hit2[k-1]) ld2 = sb[k].load;
    end
    k1   = youngest_match(hit1);
    k2   = youngest_match(hit2);
    haz1 = (k1 != '0) && ld1 && (int'(k1) < LOAD_READY);
    haz2 = (k2 != '0) && ld2 && (int'(k2) < LOAD_READY);
  end

  assign fwd_r1_sel = haz1 ? '0 : SEL_W'(k1);
  assign fwd_r2_sel = haz2 ? '0 : SEL_W'(k2);
  assign stall      = (haz1 | haz2) & ~flush;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = id_valid & id_we & (id_dst != '0);
    new_entry.dst   = MAX_REG_W'(id_dst);
    new_entry.load  = id_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= STAGES; k++) sb[k] <= '0;
      stall_cnt <= '0;
    end else begin
      sb[1] <= (flush || stall) ? '0 : new_entry;
      // A flush squashes the instruction currently at stage 1 as well.
      for (int k = 2; k <= STAGES; k++) sb[k] <= (k == 2 && flush) ? '0 : sb[k-1];
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
